overdrive_arbiter: RTL and testbench
====================================

OVERDRIVE_ARBITER -- requirements
Module: overdrive_arbiter

Interface
REQ-001 Parameter OD_LATENCY, default 1: cycles from od_in_frame to valid od_out_frame; legal range 1-4.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RESET_N  in  1  reset, synchronous, active-low.
REQ-004 l_req  in  1  left channel frame request; held high until l_ack.
REQ-005 l_frame  in  16  left signed frame; stable while l_req high.
REQ-006 l_gain  in  1  left clip level select (1 = high, 0 = low); stable while l_req high.
REQ-007 l_ack  out  1  one-cycle pulse: left request accepted.
REQ-008 r_req / r_frame / r_gain / r_ack  in/in/in/out  1/16/1/1  right channel; same rules as left.
REQ-009 od_in_frame  out  16  frame driven into the shared overdrive datapath.
REQ-010 od_gain  out  1  gain driven into the shared overdrive datapath.
REQ-011 od_out_frame  in  16  clipped result from the datapath.
REQ-012 l_out / r_out  out  16  last processed frame per channel.
REQ-013 l_out_valid / r_out_valid  out  1  one-cycle pulse: matching out register updated.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 The block SHALL time-share one overdrive datapath between the left and right channels, one frame in flight at a time.
REQ-016 The FSM SHALL have states IDLE, WAIT, RETURN.
REQ-017 IDLE: l_req and r_req sampled each edge; if either is high, go to WAIT, latch the winner's frame into od_in_frame, its gain into od_gain, and record the winner in owner.
REQ-018 Arbitration: one request only -> that channel wins; both -> the channel not equal to last_grant wins; last_grant updates to the winner.
REQ-019 The winner's ack SHALL be high for exactly the first WAIT cycle; the loser gets no ack and keeps its request pending.
REQ-020 req SHALL be ignored outside IDLE; a req still high during the ack cycle SHALL NOT cause a second grant.
REQ-021 WAIT SHALL last exactly OD_LATENCY+1 cycles, counted by a down-counter loaded on IDLE exit; od_in_frame and od_gain SHALL hold constant throughout WAIT.
REQ-022 On the edge ending WAIT: od_out_frame captured into owner's out register, owner's out_valid set, state -> RETURN.
REQ-023 RETURN SHALL last one cycle with the out_valid pulse high, then go to IDLE and clear out_valid.
REQ-024 Per-frame occupancy SHALL be OD_LATENCY+3 cycles from req sampled to IDLE re-entry (OD_LATENCY=1: 4 cycles).
REQ-025 The non-owner channel's out register and out_valid SHALL be unchanged by a transaction.
REQ-026 Frame data SHALL pass unmodified in both directions (no sign extension, no shifting); od_in_frame holds its last value in IDLE.
REQ-027 Only one of l_ack/r_ack and only one of l_out_valid/r_out_valid SHALL be high in any cycle.

Reset
REQ-028 RESET_N low at an edge SHALL force state IDLE, counter 0, last_grant = RIGHT (left wins the first tie), owner = LEFT.
REQ-029 Reset values: l_ack, r_ack, l_out_valid, r_out_valid, busy = 0; od_in_frame, l_out, r_out = 16'h0000; od_gain = 0.
REQ-030 Reset in WAIT or RETURN SHALL abort the frame: no out register update, no out_valid pulse after reset; requester re-requests.
REQ-031 The first req sampled after RESET_N returns high SHALL be arbitrated normally.

Verification
REQ-032 Single left: l_req=1, l_frame=16'h1000, l_gain=1, OD_LATENCY=1, model datapath as 1-cycle reg -> l_ack on cycle 1, od_in_frame=16'h1000, od_gain=1 in cycles 1-2, l_out = datapath result with l_out_valid in cycle 3, busy low in cycle 4.
REQ-033 Tie: l_req and r_req high together, both held after reset -> left served first, then right with no idle gap beyond one IDLE cycle; repeat tie -> left again after right (alternation).
REQ-034 Back-to-back right only: r_req held continuously with new r_frame per ack -> r_ack every 4 cycles (OD_LATENCY=1), 7 cycles (OD_LATENCY=4); l_out never changes.
REQ-035 Negative passthrough: r_frame=16'hC000, datapath returns 16'hD8F0 -> r_out=16'hD8F0 exactly, od_in_frame=16'hC000.
REQ-036 Reset mid-WAIT: grant left, assert RESET_N=0 for one edge in the second WAIT cycle -> all outputs at reset values, no l_out_valid, l_out=16'h0000.
REQ-037 Late request: r_req rises during a left WAIT -> no r_ack until the cycle after the left RETURN→IDLE edge; r_ack then pulses once.

Source files
------------

// File: rtl/overdrive_arbiter.sv
// Shares one external overdrive datapath between a left and a right frame channel.
// One frame is in flight at a time. Ties alternate, starting with the left channel after reset.
module overdrive_arbiter #(
   parameter int OD_LATENCY = 1
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        l_req,
   input  logic [15:0] l_frame,
   input  logic        l_gain,
   output logic        l_ack,
   input  logic        r_req,
   input  logic [15:0] r_frame,
   input  logic        r_gain,
   output logic        r_ack,
   output logic [15:0] od_in_frame,
   output logic        od_gain,
   input  logic [15:0] od_out_frame,
   output logic [15:0] l_out,
   output logic [15:0] r_out,
   output logic        l_out_valid,
   output logic        r_out_valid,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   // Handshake: a requester holds req high with frame/gain stable until its ack
   // pulse, which is high for exactly the first WAIT cycle. The requester drops
   // req after the ack. Any req seen outside IDLE is ignored.

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_RETURN = 2'd2
   } state_t;

   localparam logic       CH_LEFT  = 1'b0;
   localparam logic       CH_RIGHT = 1'b1;
   localparam logic [2:0] CNT_LOAD = 3'(OD_LATENCY);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_cnt;
   logic        r_last_grant;
   logic        r_owner;
   logic        r_l_ack;
   logic        r_r_ack;
   logic        r_l_out_valid;
   logic        r_r_out_valid;
   logic [15:0] r_od_in_frame;
   logic        r_od_gain;
   logic [15:0] r_l_out;
   logic [15:0] r_r_out;

   logic        w_grant;
   logic        w_winner;
   logic        w_wait_done;

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_winner    = CH_LEFT;
      w_wait_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (l_req || r_req) begin
               w_grant     = 1'b1;
               w_state_nxt = ST_WAIT;
               if (l_req && r_req) begin
                  w_winner = (r_last_grant == CH_RIGHT) ? CH_LEFT : CH_RIGHT;
               end else begin
                  w_winner = r_req ? CH_RIGHT : CH_LEFT;
               end
            end
         end
         ST_WAIT: begin
            // Counter was loaded with OD_LATENCY, so WAIT spans OD_LATENCY+1 cycles.
            if (r_cnt == 3'd0) begin
               w_wait_done = 1'b1;
               w_state_nxt = ST_RETURN;
            end
         end
         ST_RETURN: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         r_state       <= ST_IDLE;
         r_cnt         <= 3'd0;
         r_last_grant  <= CH_RIGHT;
         r_owner       <= CH_LEFT;
         r_l_ack       <= 1'b0;
         r_r_ack       <= 1'b0;
         r_l_out_valid <= 1'b0;
         r_r_out_valid <= 1'b0;
         r_od_in_frame <= 16'h0000;
         r_od_gain     <= 1'b0;
         r_l_out       <= 16'h0000;
         r_r_out       <= 16'h0000;
      end else begin
         r_state       <= w_state_nxt;
         r_l_ack       <= w_grant && (w_winner == CH_LEFT);
         r_r_ack       <= w_grant && (w_winner == CH_RIGHT);
         r_l_out_valid <= w_wait_done && (r_owner == CH_LEFT);
         r_r_out_valid <= w_wait_done && (r_owner == CH_RIGHT);
         if (w_grant) begin
            r_od_in_frame <= (w_winner == CH_RIGHT) ? r_frame : l_frame;
            r_od_gain     <= (w_winner == CH_RIGHT) ? r_gain : l_gain;
            r_owner       <= w_winner;
            r_last_grant  <= w_winner;
            r_cnt         <= CNT_LOAD;
         end else if ((r_state == ST_WAIT) && (r_cnt != 3'd0)) begin
            r_cnt <= r_cnt - 3'd1;
         end
         if (w_wait_done) begin
            if (r_owner == CH_RIGHT) begin
               r_r_out <= od_out_frame;
            end else begin
               r_l_out <= od_out_frame;
            end
         end
      end
   end

   assign l_ack       = r_l_ack;
   assign r_ack       = r_r_ack;
   assign l_out_valid = r_l_out_valid;
   assign r_out_valid = r_r_out_valid;
   assign od_in_frame = r_od_in_frame;
   assign od_gain     = r_od_gain;
   assign l_out       = r_l_out;
   assign r_out       = r_r_out;
   assign busy        = (r_state != ST_IDLE);
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_overdrive_arbiter.sv
// Directed bench for overdrive_arbiter: latency-1 instance for arbitration/reset cases,
// plus a latency-4 instance for back-to-back throughput.
module tb_overdrive_arbiter;

   logic        CLK;
   logic        RESET_N;
   logic        l_req, r_req, l_gain, r_gain;
   logic [15:0] l_frame, r_frame;
   logic        l_ack, r_ack, od_gain, l_out_valid, r_out_valid, busy;
   logic [15:0] od_in_frame, od_out_frame, l_out, r_out;
   logic [1:0]  dbg_state;

   logic        r_req4, r_gain4;
   logic [15:0] r_frame4;
   logic        l_ack4, r_ack4, od_gain4, l_out_valid4, r_out_valid4, busy4;
   logic [15:0] od_in_frame4, od_out_frame4, l_out4, r_out4;
   logic [1:0]  dbg_state4;
   logic [15:0] dp4 [4];

   logic [15:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   overdrive_arbiter #(.OD_LATENCY(1)) u_dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .l_req(l_req), .l_frame(l_frame), .l_gain(l_gain), .l_ack(l_ack),
      .r_req(r_req), .r_frame(r_frame), .r_gain(r_gain), .r_ack(r_ack),
      .od_in_frame(od_in_frame), .od_gain(od_gain), .od_out_frame(od_out_frame),
      .l_out(l_out), .r_out(r_out), .l_out_valid(l_out_valid), .r_out_valid(r_out_valid),
      .busy(busy), .dbg_state(dbg_state)
   );

   overdrive_arbiter #(.OD_LATENCY(4)) u_dut4 (
      .CLK(CLK), .RESET_N(RESET_N),
      .l_req(1'b0), .l_frame(16'h0000), .l_gain(1'b0), .l_ack(l_ack4),
      .r_req(r_req4), .r_frame(r_frame4), .r_gain(r_gain4), .r_ack(r_ack4),
      .od_in_frame(od_in_frame4), .od_gain(od_gain4), .od_out_frame(od_out_frame4),
      .l_out(l_out4), .r_out(r_out4), .l_out_valid(l_out_valid4), .r_out_valid(r_out_valid4),
      .busy(busy4), .dbg_state(dbg_state4)
   );

   // Datapath stand-in: a fixed XOR pattern per gain so results are easy to hand-compute.
   function automatic logic [15:0] dp_f(input logic [15:0] f, input logic g);
      return f ^ (g ? 16'h18F0 : 16'h0F0F);
   endfunction

   always_ff @(posedge CLK) od_out_frame <= dp_f(od_in_frame, od_gain);

   always_ff @(posedge CLK) begin
      dp4[0] <= dp_f(od_in_frame4, od_gain4);
      for (int i = 1; i < 4; i++) dp4[i] <= dp4[i-1];
   end
   assign od_out_frame4 = dp4[3];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      RESET_N = 1'b0;
      l_req = 1'b0; l_frame = 16'h0000; l_gain = 1'b0;
      r_req = 1'b0; r_frame = 16'h0000; r_gain = 1'b0;
      r_req4 = 1'b0; r_frame4 = 16'h0000; r_gain4 = 1'b0;
      repeat (3) tick();

      // Reset values
      check1("rst_l_ack", l_ack, 1'b0);
      check1("rst_r_ack", r_ack, 1'b0);
      check1("rst_l_valid", l_out_valid, 1'b0);
      check1("rst_r_valid", r_out_valid, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_od_gain", od_gain, 1'b0);
      check16("rst_od_in", od_in_frame, 16'h0000);
      check16("rst_l_out", l_out, 16'h0000);
      check16("rst_r_out", r_out, 16'h0000);
      check16("rst_state", 16'(dbg_state), 16'd0);
      RESET_N = 1'b1;
      tick();

      // Single left request, latency 1
      l_req = 1'b1; l_frame = 16'h1000; l_gain = 1'b1;
      tick();
      check1("sl_c1_l_ack", l_ack, 1'b1);
      check1("sl_c1_r_ack", r_ack, 1'b0);
      check16("sl_c1_od_in", od_in_frame, 16'h1000);
      check1("sl_c1_od_gain", od_gain, 1'b1);
      check1("sl_c1_busy", busy, 1'b1);
      check16("sl_c1_state", 16'(dbg_state), 16'd1);
      l_req = 1'b0; l_frame = 16'hFFFF; l_gain = 1'b0;
      tick();
      check1("sl_c2_l_ack", l_ack, 1'b0);
      check16("sl_c2_od_in", od_in_frame, 16'h1000);
      check1("sl_c2_od_gain", od_gain, 1'b1);
      check1("sl_c2_l_valid", l_out_valid, 1'b0);
      tick();
      check1("sl_c3_l_valid", l_out_valid, 1'b1);
      check1("sl_c3_r_valid", r_out_valid, 1'b0);
      check16("sl_c3_l_out", l_out, 16'h08F0);
      check16("sl_c3_state", 16'(dbg_state), 16'd2);
      tick();
      check1("sl_c4_busy", busy, 1'b0);
      check1("sl_c4_l_valid", l_out_valid, 1'b0);
      check16("sl_c4_l_out", l_out, 16'h08F0);
      check16("sl_c4_od_in_hold", od_in_frame, 16'h1000);
      check16("sl_c4_r_out", r_out, 16'h0000);

      // Reset during the second WAIT cycle aborts the frame
      l_req = 1'b1; l_frame = 16'h7FFF; l_gain = 1'b0;
      tick();
      check1("rw_c1_l_ack", l_ack, 1'b1);
      l_req = 1'b0;
      tick();
      check16("rw_c2_state", 16'(dbg_state), 16'd1);
      RESET_N = 1'b0;
      tick();
      check16("rw_state", 16'(dbg_state), 16'd0);
      check1("rw_busy", busy, 1'b0);
      check1("rw_l_valid", l_out_valid, 1'b0);
      check16("rw_l_out", l_out, 16'h0000);
      check16("rw_od_in", od_in_frame, 16'h0000);
      check1("rw_od_gain", od_gain, 1'b0);
      check1("rw_l_ack", l_ack, 1'b0);
      RESET_N = 1'b1;
      tick();
      check1("rw_c4_l_valid", l_out_valid, 1'b0);
      check1("rw_c4_busy", busy, 1'b0);
      tick();
      check1("rw_c5_l_valid", l_out_valid, 1'b0);
      check16("rw_c5_l_out", l_out, 16'h0000);

      // Tie after reset: left first, then right, then left again
      l_req = 1'b1; l_frame = 16'h1234; l_gain = 1'b0;
      r_req = 1'b1; r_frame = 16'hC000; r_gain = 1'b1;
      tick();
      check1("t1_c1_l_ack", l_ack, 1'b1);
      check1("t1_c1_r_ack", r_ack, 1'b0);
      check16("t1_c1_od_in", od_in_frame, 16'h1234);
      l_req = 1'b0;
      tick();
      check1("t1_c2_r_ack", r_ack, 1'b0);
      tick();
      check1("t1_c3_l_valid", l_out_valid, 1'b1);
      check16("t1_c3_l_out", l_out, 16'h1D3B);
      check16("t1_c3_r_out", r_out, 16'h0000);
      tick();
      check16("t1_c4_state", 16'(dbg_state), 16'd0);
      check1("t1_c4_r_ack", r_ack, 1'b0);
      tick();
      check1("t1_c5_r_ack", r_ack, 1'b1);
      check1("t1_c5_l_ack", l_ack, 1'b0);
      check16("t1_c5_od_in", od_in_frame, 16'hC000);
      check1("t1_c5_od_gain", od_gain, 1'b1);
      r_req = 1'b0;
      tick();
      tick();
      check1("t1_c7_r_valid", r_out_valid, 1'b1);
      check1("t1_c7_l_valid", l_out_valid, 1'b0);
      check16("t1_c7_r_out", r_out, 16'hD8F0);
      check16("t1_c7_l_out", l_out, 16'h1D3B);
      tick();
      check1("t1_c8_busy", busy, 1'b0);
      l_req = 1'b1; l_frame = 16'h2222; l_gain = 1'b1;
      r_req = 1'b1; r_frame = 16'h0F0F; r_gain = 1'b0;
      tick();
      check1("t2_c1_l_ack", l_ack, 1'b1);
      check1("t2_c1_r_ack", r_ack, 1'b0);
      l_req = 1'b0;
      repeat (2) tick();
      check16("t2_c3_l_out", l_out, 16'h3AD2);
      repeat (2) tick();
      check1("t2_c5_r_ack", r_ack, 1'b1);
      r_req = 1'b0;
      repeat (2) tick();
      check1("t2_c7_r_valid", r_out_valid, 1'b1);
      check16("t2_c7_r_out", r_out, 16'h0000);
      tick();

      // Late right request during a left WAIT
      l_req = 1'b1; l_frame = 16'h00AA; l_gain = 1'b0;
      tick();
      check1("lr_c1_l_ack", l_ack, 1'b1);
      l_req = 1'b0;
      tick();
      r_req = 1'b1; r_frame = 16'h0001; r_gain = 1'b0;
      tick();
      check1("lr_c3_r_ack", r_ack, 1'b0);
      check1("lr_c3_l_valid", l_out_valid, 1'b1);
      check16("lr_c3_l_out", l_out, 16'h0FA5);
      tick();
      check1("lr_c4_r_ack", r_ack, 1'b0);
      check16("lr_c4_state", 16'(dbg_state), 16'd0);
      tick();
      check1("lr_c5_r_ack", r_ack, 1'b1);
      r_req = 1'b0;
      tick();
      check1("lr_c6_r_ack", r_ack, 1'b0);
      tick();
      check1("lr_c7_r_valid", r_out_valid, 1'b1);
      check16("lr_c7_r_out", r_out, 16'h0F0E);
      tick();

      // Back-to-back right, latency 1: ack every 4 cycles
      r_req = 1'b1; r_frame = 16'h0100; r_gain = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         check1("b1_r_ack", r_ack, (c % 4) == 1);
         check1("b1_r_valid", r_out_valid, (c % 4) == 3);
         check1("b1_l_valid", l_out_valid, 1'b0);
         check16("b1_l_out", l_out, 16'h0FA5);
         if (r_ack) begin
            exp_q.push_back(dp_f(r_frame, r_gain));
            r_frame = r_frame + 16'h0100;
         end
         if (r_out_valid) begin
            if (exp_q.size() == 0) check1("b1_extra_valid", r_out_valid, 1'b0);
            else check16("b1_r_out", r_out, exp_q.pop_front());
         end
      end
      r_req = 1'b0;
      tick();
      exp_q.delete();

      // Back-to-back right, latency 4: ack every 7 cycles
      r_req4 = 1'b1; r_frame4 = 16'h8001; r_gain4 = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         tick();
         check1("b4_r_ack", r_ack4, (c % 7) == 1);
         check1("b4_r_valid", r_out_valid4, (c % 7) == 6);
         check1("b4_l_ack", l_ack4, 1'b0);
         check1("b4_l_valid", l_out_valid4, 1'b0);
         check16("b4_l_out", l_out4, 16'h0000);
         if (r_ack4) begin
            exp_q.push_back(dp_f(r_frame4, r_gain4));
            r_frame4 = r_frame4 + 16'h1111;
         end
         if (r_out_valid4) begin
            if (exp_q.size() == 0) check1("b4_extra_valid", r_out_valid4, 1'b0);
            else check16("b4_r_out", r_out4, exp_q.pop_front());
         end
      end
      r_req4 = 1'b0;
      tick();
      check1("b4_idle_busy", busy4, 1'b0);
      check16("b4_state", 16'(dbg_state4), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
